// File: rtl/aia_msi_pkg.sv
// Shared types and constants for the AIA MSI transmitter.
// Optional build macro used by the top: AIA_MSI_TX_BE_EN (big-endian seteipnum target).
package aia_msi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_B
    } msi_state_e;

    // Register offsets inside one IMSIC interrupt file and the file-to-file stride
    localparam logic [11:0] SETEIPNUM_LE_OFF  = 12'h000;
    localparam logic [11:0] SETEIPNUM_BE_OFF  = 12'h004;
    localparam int unsigned FILE_STRIDE_SHIFT = 12;

    // AXI write response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Queue entries are sized for the largest legal configuration
    localparam int unsigned MAX_FILE_W = 8;
    localparam int unsigned MAX_EIID_W = 11;

    typedef struct packed {
        logic [MAX_FILE_W-1:0] file;
        logic [MAX_EIID_W-1:0] eiid;
    } msi_req_t;

endpackage

// File: rtl/aia_msi_req_fifo.sv
// Request queue for the MSI transmitter: power-of-two depth, registered full/empty flags.
// A push while full is taken only when a pop happens in the same cycle.
module aia_msi_req_fifo
    import aia_msi_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  msi_req_t data_in,
    input  logic     pop,
    output msi_req_t data_out,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    msi_req_t        mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic [CntW-1:0] count_next;
    logic            do_push;
    logic            do_pop;

    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign count_next = count + CntW'(do_push) - CntW'(do_pop);
    assign data_out   = mem[rd_ptr];

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and the registered full/empty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count_next;
            full  <= (count_next == CntW'(Depth));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/aia_msi_tx.sv
// AIA MSI transmitter: queues (file, eiid) requests and posts each one as a single-beat
// AXI write to the target IMSIC file's seteipnum register, retrying on error responses.
// Build macro AIA_MSI_TX_BE_EN selects the big-endian seteipnum_be register instead.
module aia_msi_tx
    import aia_msi_pkg::*;
#(
    parameter int unsigned NrIntpFiles = 3,
    parameter int unsigned NrSources   = 256,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned AxiId       = 0,
    parameter logic [63:0] ImsicBase   = 64'h2800_0000,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned MaxRetries  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [$clog2(NrIntpFiles)-1:0] req_file_i,
    input  logic [$clog2(NrSources)-1:0]   req_eiid_i,
    output logic                           aw_valid_o,
    input  logic                           aw_ready_i,
    output logic [AddrWidth-1:0]           aw_addr_o,
    output logic [IdWidth-1:0]             aw_id_o,
    output logic                           w_valid_o,
    input  logic                           w_ready_i,
    output logic [DataWidth-1:0]           w_data_o,
    output logic [DataWidth/8-1:0]         w_strb_o,
    input  logic                           b_valid_i,
    output logic                           b_ready_o,
    input  logic [1:0]                     b_resp_i,
    input  logic [IdWidth-1:0]             b_id_i,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [15:0]                    drop_cnt_o
);

    localparam int unsigned RetryW = $clog2(MaxRetries + 2);

`ifdef AIA_MSI_TX_BE_EN
    localparam logic [11:0] RegOff = SETEIPNUM_BE_OFF;
`else
    localparam logic [11:0] RegOff = SETEIPNUM_LE_OFF;
`endif

    msi_state_e          state;
    msi_req_t            in_req;
    msi_req_t            head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                invalid;
    logic                push;
    logic                pop;
    logic                aw_done;
    logic                w_done;
    logic                aw_fire;
    logic                w_fire;
    logic [RetryW-1:0]   retries;
    logic                b_match;
    logic                b_ok;
    logic                fsm_drop;
    logic [1:0]          drop_inc;
    logic [16:0]         drop_sum;
    logic [AddrWidth-1:0] next_addr;
    logic [63:0]         next_data;
    logic [7:0]          next_strb;
    logic [31:0]         eiid32;

    assign req_ready_o = !fifo_full;
    assign accept      = req_valid_i && req_ready_o;
    assign invalid     = (req_eiid_i == '0) || (32'(req_file_i) >= NrIntpFiles);
    assign push        = accept && !invalid;
    assign pop         = (state == IDLE) && !fifo_empty;
    assign in_req.file = MAX_FILE_W'(req_file_i);
    assign in_req.eiid = MAX_EIID_W'(req_eiid_i);

    assign aw_id_o  = IdWidth'(AxiId);
    assign busy_o   = !fifo_empty || (state != IDLE);
    assign aw_fire  = aw_valid_o && aw_ready_i;
    assign w_fire   = w_valid_o && w_ready_i;
    assign b_match  = b_valid_i && (b_id_i == IdWidth'(AxiId));
    assign b_ok     = (b_resp_i == RESP_OKAY) || (b_resp_i == RESP_EXOKAY);
    assign fsm_drop = (state == WAIT_B) && b_match && !b_ok && (retries >= RetryW'(MaxRetries));

    aia_msi_req_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push     (push),
        .data_in  (in_req),
        .pop      (pop),
        .data_out (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Write payload for the queue head, latched when the FSM picks the entry up
    always_comb begin
        eiid32    = 32'(head.eiid);
        next_addr = AddrWidth'(ImsicBase) + (AddrWidth'(head.file) << FILE_STRIDE_SHIFT)
                  + AddrWidth'(RegOff);
`ifdef AIA_MSI_TX_BE_EN
        next_data = {eiid32[7:0], eiid32[15:8], eiid32[23:16], eiid32[31:24], 32'h0};
        next_strb = 8'hF0;
`else
        next_data = {32'h0, eiid32};
        next_strb = 8'h0F;
`endif
    end

    // Transaction FSM: pick up head, drive AW/W independently, then wait for a matching B
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            aw_valid_o <= 1'b0;
            w_valid_o  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            b_ready_o  <= 1'b0;
            err_o      <= 1'b0;
            retries    <= '0;
            aw_addr_o  <= '0;
            w_data_o   <= '0;
            w_strb_o   <= '0;
        end else begin
            err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        aw_addr_o  <= next_addr;
                        w_data_o   <= next_data;
                        w_strb_o   <= next_strb;
                        aw_valid_o <= 1'b1;
                        w_valid_o  <= 1'b1;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (aw_fire) begin
                        aw_valid_o <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_fire) begin
                        w_valid_o <= 1'b0;
                        w_done    <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        b_ready_o <= 1'b1;
                        state     <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_match) begin
                        b_ready_o <= 1'b0;
                        if (b_ok) begin
                            retries <= '0;
                            state   <= IDLE;
                        end else if (fsm_drop) begin
                            retries <= '0;
                            err_o   <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            // Payload registers are untouched, so the resend is identical
                            retries    <= retries + RetryW'(1);
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                            aw_done    <= 1'b0;
                            w_done     <= 1'b0;
                            state      <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign drop_inc = {1'b0, accept && invalid} + {1'b0, fsm_drop};
    assign drop_sum = {1'b0, drop_cnt_o} + 17'(drop_inc);

    // Saturating count of discarded requests (input discards plus exhausted retries)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else begin
            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_aia_msi_tx.sv
// Self-checking bench for aia_msi_tx: table-driven requests plus hand-written corner
// sequences, with a scoreboard of expected AW/W payloads checked at each handshake.
`timescale 1ns/1ps
module tb_aia_msi_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready;
    logic [1:0]  req_file;
    logic [8:0]  req_eiid;
    logic        aw_valid, aw_ready;
    logic [63:0] aw_addr;
    logic [3:0]  aw_id;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        err, busy;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    aia_msi_tx #(
        .NrSources (512)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_file_i  (req_file),
        .req_eiid_i  (req_eiid),
        .aw_valid_o  (aw_valid),
        .aw_ready_i  (aw_ready),
        .aw_addr_o   (aw_addr),
        .aw_id_o     (aw_id),
        .w_valid_o   (w_valid),
        .w_ready_i   (w_ready),
        .w_data_o    (w_data),
        .w_strb_o    (w_strb),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready),
        .b_resp_i    (b_resp),
        .b_id_i      (b_id),
        .err_o       (err),
        .busy_o      (busy),
        .drop_cnt_o  (drop_cnt)
    );

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bresp_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
    } wpay_t;

    typedef struct {
        int file;
        int eiid;
        bit on_bus;
    } vec_t;

    bresp_t      b_plan[$];
    logic [63:0] exp_aw[$];
    wpay_t       exp_w[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int aw_hs = 0;
    int w_hs = 0;
    int aw_hs_cyc = 0;
    int w_hs_cyc = 0;
    int err_seen = 0;
    int exp_drop = 0;
    int t_push = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] m_addr(input int f);
`ifdef AIA_MSI_TX_BE_EN
        return 64'h2800_0000 + 64'(f) * 64'h1000 + 64'h4;
`else
        return 64'h2800_0000 + 64'(f) * 64'h1000;
`endif
    endfunction

    function automatic wpay_t m_wpay(input int e);
        logic [31:0] v;
        wpay_t p;
        v = 32'(e);
`ifdef AIA_MSI_TX_BE_EN
        p.data = {v[7:0], v[15:8], v[23:16], v[31:24], 32'h0};
        p.strb = 8'hF0;
`else
        p.data = {32'h0, v};
        p.strb = 8'h0F;
`endif
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request for one cycle; valid requests add `copies` expected bus writes
    task automatic push_req(input int f, input int e, input bit exp_acc, input int copies);
        bit acc;
        req_file  = 2'(f);
        req_eiid  = 9'(e);
        req_valid = 1'b1;
        acc       = req_ready;
        t_push    = cyc;
        check("req_ready_on_push", 64'(acc), 64'(exp_acc));
        if (acc) begin
            if (e != 0 && f < 3) begin
                for (int i = 0; i < copies; i++) begin
                    exp_aw.push_back(m_addr(f));
                    exp_w.push_back(m_wpay(e));
                end
            end else begin
                exp_drop++;
            end
        end
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_aw();
        int i;
        for (i = 0; i < 50; i++) begin
            if (aw_valid) break;
            step(1);
        end
        if (i == 50) check("aw_valid_timeout", 64'(aw_valid), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            step(1);
        end
        check(name, 64'(busy), 64'd0);
    endtask

    // Scoreboard: compare each AW/W handshake against the next expected payload
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_valid && aw_ready) begin
                aw_hs++;
                aw_hs_cyc = cyc;
                if (exp_aw.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL aw_unexpected: got addr 0x%0h, expected no write", aw_addr);
                end else begin
                    check("aw_addr", aw_addr, exp_aw.pop_front());
                end
                check("aw_id", 64'(aw_id), 64'd0);
            end
            if (w_valid && w_ready) begin
                w_hs++;
                w_hs_cyc = cyc;
                if (exp_w.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL w_unexpected: got data 0x%0h, expected no write", w_data);
                end else begin
                    wpay_t p;
                    p = exp_w.pop_front();
                    check("w_data", w_data, p.data);
                    check("w_strb", 64'(w_strb), 64'(p.strb));
                end
            end
            if (err) err_seen++;
        end
    end

    // B responder: answers two cycles into WAIT_B from b_plan, defaulting to OKAY on ID 0
    initial begin
        int b_wait;
        bresp_t e;
        b_wait  = 0;
        b_valid = 1'b0;
        b_resp  = 2'b00;
        b_id    = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (b_valid) begin
                b_valid = 1'b0;
            end else if (b_ready) begin
                if (b_wait < 1) begin
                    b_wait++;
                end else begin
                    b_wait  = 0;
                    b_valid = 1'b1;
                    if (b_plan.size() != 0) begin
                        e      = b_plan.pop_front();
                        b_resp = e.resp;
                        b_id   = e.id;
                    end else begin
                        b_resp = 2'b00;
                        b_id   = 4'd0;
                    end
                end
            end else begin
                b_wait = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int   aw0, w0, err0;

        req_valid = 1'b0;
        req_file  = '0;
        req_eiid  = '0;
        aw_ready  = 1'b1;
        w_ready   = 1'b1;
        step(3);

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_aw_addr", aw_addr, 64'd0);
        check("rst_w_data", w_data, 64'd0);
        check("rst_w_strb", 64'(w_strb), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Basic write and enqueue-to-AW latency
        push_req(1, 37, 1'b1, 1);
        wait_aw();
        check("aw_latency", 64'(cyc - t_push), 64'd2);
`ifdef AIA_MSI_TX_BE_EN
        check("basic_addr", aw_addr, 64'h2800_1004);
        check("basic_data", w_data, 64'h2500_0000_0000_0000);
        check("basic_strb", 64'(w_strb), 64'hF0);
`else
        check("basic_addr", aw_addr, 64'h2800_1000);
        check("basic_data", w_data, 64'h25);
        check("basic_strb", 64'(w_strb), 64'h0F);
`endif
        wait_idle("basic_busy_clear");

        // AW ready delayed, W accepted first; AW held with stable address
        aw_ready = 1'b0;
        aw0 = aw_hs;
        w0  = w_hs;
        push_req(2, 100, 1'b1, 1);
        wait_aw();
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("aw_hold_valid", 64'(aw_valid), 64'd1);
            check("aw_hold_addr", aw_addr, m_addr(2));
            check("w_cleared", 64'(w_valid), 64'd0);
        end
        aw_ready = 1'b1;
        wait_idle("split_busy_clear");
        check("split_aw_count", 64'(aw_hs - aw0), 64'd1);
        check("split_w_count", 64'(w_hs - w0), 64'd1);
        check("split_w_first", 64'(w_hs_cyc < aw_hs_cyc), 64'd1);

        // Foreign-ID response ignored, then three errors: two resends then drop
        b_plan.push_back('{2'b00, 4'd5});
        b_plan.push_back('{2'b10, 4'd0});
        b_plan.push_back('{2'b11, 4'd0});
        b_plan.push_back('{2'b10, 4'd0});
        err0 = err_seen;
        aw0  = aw_hs;
        push_req(0, 5, 1'b1, 3);
        push_req(1, 6, 1'b1, 1);
        exp_drop++;
        wait_idle("retry_busy_clear");
        check("retry_err_pulses", 64'(err_seen - err0), 64'd1);
        check("retry_aw_count", 64'(aw_hs - aw0), 64'd4);
        check("retry_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        // Table-driven requests including input discards
        vecs[0] = '{2, 1, 1'b1};
        vecs[1] = '{0, 255, 1'b1};
        vecs[2] = '{0, 0, 1'b0};
        vecs[3] = '{3, 9, 1'b0};
        vecs[4] = '{1, 511, 1'b1};
        vecs[5] = '{2, 200, 1'b1};
        aw0 = aw_hs;
        for (int i = 0; i < 6; i++) begin
            push_req(vecs[i].file, vecs[i].eiid, 1'b1, 1);
        end
        wait_idle("table_busy_clear");
        check("table_aw_count", 64'(aw_hs - aw0), 64'd4);
        check("table_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        check("table_req_ready", 64'(req_ready), 64'd1);

        // Queue full: one request in flight, four queued, fifth refused
        aw_ready = 1'b0;
        push_req(2, 7, 1'b1, 1);
        wait_aw();
        for (int i = 0; i < 5; i++) begin
            push_req(i % 3, 50 + i, i < 4, 1);
        end
        check("full_req_ready", 64'(req_ready), 64'd0);
        aw_ready = 1'b1;
        wait_idle("full_busy_clear");
        check("full_req_ready_back", 64'(req_ready), 64'd1);

        // Register variant check on file 0 with a multi-byte identity
        push_req(0, 'h102, 1'b1, 1);
        wait_aw();
`ifdef AIA_MSI_TX_BE_EN
        check("var_addr", aw_addr, 64'h2800_0004);
        check("var_data", w_data, 64'h0201_0000_0000_0000);
        check("var_strb", 64'(w_strb), 64'hF0);
`else
        check("var_addr", aw_addr, 64'h2800_0000);
        check("var_data", w_data, 64'h102);
        check("var_strb", 64'(w_strb), 64'h0F);
`endif
        wait_idle("var_busy_clear");

        // Reset in the middle of a transaction
        aw_ready = 1'b0;
        push_req(1, 9, 1'b1, 1);
        wait_aw();
        rst_n = 1'b0;
        #1;
        check("midrst_aw_valid", 64'(aw_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        exp_aw.delete();
        exp_w.delete();
        exp_drop = 0;
        step(2);
        rst_n    = 1'b1;
        aw_ready = 1'b1;
        step(2);
        push_req(2, 3, 1'b1, 1);
        wait_idle("post_rst_busy_clear");

        check("sb_aw_drained", 64'(exp_aw.size()), 64'd0);
        check("sb_w_drained", 64'(exp_w.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
